gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Free-running up-counter whose output is Gray-coded; consecutive output values differ in exactly one bit.
- Supports synchronous parallel load of a Gray-coded value.
- Used as a pointer/sequence generator where single-bit transitions are required, e.g. clock-domain-crossing pointers or low-glitch state encoding.
- Single clock domain, synchronous active-high reset.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk only.
- reset  input  1  synchronous, active-high reset; highest priority.
- load_en  input  1  synchronous parallel-load enable, active-high.
- d  input  WIDTH  Gray-coded load value, sampled when load_en=1.
- q  output  WIDTH  current Gray-coded count, driven directly from a register.

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and reset.
- Priority at each posedge clk: reset, then load_en, then count.
- reset=1: q <= 0. Reset value of q is all zeros. load_en and d are ignored while reset=1.
- reset=0, load_en=1: q <= d. d is taken as a Gray code and loaded verbatim, with no conversion.
- reset=0, load_en=0: q <= next Gray code after q.
  - next = bin2gray(gray2bin(q) + 1), computed modulo 2^WIDTH.
  - gray2bin: b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i].
  - bin2gray: g = b XOR (b >> 1).
- There is no count enable; the counter advances every cycle it is not in reset or load.
- 4-bit sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
- Wrap-around: the code with binary equivalent 2^WIDTH-1 (1000 for WIDTH=4) advances to 0000. No overflow flag.
- Exactly one bit of q toggles on each count step, including the wrap step. Load and reset may change several bits at once.
- Latency: one cycle; q reflects reset/load/count on the clock edge where the controls are sampled.
- Reset asserted mid-count: q becomes 0 at the next edge. After reset deasserts, counting resumes from 0 (first count edge gives 0001).
- Load held for several cycles: q stays at d each cycle. Counting resumes from d on the first edge with load_en=0.
- Before the first reset, q is unspecified. Benches must apply reset first.
- q is purely registered; there is no combinational path from inputs to q.

Test Plan:
- Reset: reset=1 for 1 cycle (load_en=0) -> q=0000; hold reset for 2 more edges -> q stays 0000.
- Load then count: release reset, one idle edge -> q=0001. Then load_en=1, d=0011 for one edge -> q=0011. Then load_en=0 for 4 edges -> q=0010, 0110, 0111, 0101.
- Full cycle and wrap: from reset, 16 count edges -> each successive q follows the 16-entry sequence with Hamming distance 1 between neighbours; the 16th edge returns q=0000 from 1000.
- Priority: reset=1 and load_en=1 with d=1010 at the same edge -> q=0000. Then reset=0, load_en=1 -> q=1010.
- Reset mid-operation: load 1101, count 2 edges (q=1111, 1110), assert reset one edge -> q=0000. Deassert -> q=0001.
- Load at wrap point: load d=1000, count one edge -> q=0000. Load non-sequence-adjacent d=0110 from q=0000 -> q=0110 immediately; the multi-bit change is permitted on load.

Source files
------------

// File: rtl/gray_counter.sv
// gray_counter: free-running Gray-coded up-counter with synchronous parallel load.
// Consecutive count values differ in exactly one bit, so q is safe to use as a
// clock-domain-crossing pointer. Load and reset may change several bits at once.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_bin;
  logic [WIDTH-1:0] q_bin_inc;
  logic [WIDTH-1:0] q_next_gray;
  logic [WIDTH-1:0] q_nxt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: each Gray bit marks a change between adjacent binary bits.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Increment in the binary domain; the add wraps naturally modulo 2^WIDTH.
  always_comb begin
    q_bin       = gray2bin(q);
    q_bin_inc   = q_bin + {{(WIDTH-1){1'b0}}, 1'b1};
    q_next_gray = bin2gray(q_bin_inc);
  end

  // Next-state select: reset over load over count.
  always_comb begin
    q_nxt = q_next_gray;
    if (reset) begin
      q_nxt = '0;
    end else if (load_en) begin
      q_nxt = d;
    end
  end

  // Output register; q comes straight from flops, no input-to-output path.
  always_ff @(posedge clk) begin
    q <= q_nxt;
  end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: scoreboard bench for the 4-bit Gray counter.
module tb_gray_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load_en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  int checks;
  int errors;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_q;
  logic [WIDTH-1:0] seq_tbl [16];

  gray_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .d       (d),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int seq_index(input logic [WIDTH-1:0] g);
    for (int i = 0; i < 16; i++) begin
      if (seq_tbl[i] == g) return i;
    end
    return 0;
  endfunction

  // Drive one cycle of controls, predict q, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic l, input logic [WIDTH-1:0] dv);
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] got_exp;
    logic             counting;
    @(negedge clk);
    reset   = r;
    load_en = l;
    d       = dv;
    prev     = model_q;
    counting = !r && !l;
    if (r)      model_q = '0;
    else if (l) model_q = dv;
    else        model_q = seq_tbl[(seq_index(model_q) + 1) % 16];
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got_exp = exp_q.pop_front();
      check_val(tag, {28'd0, q}, {28'd0, got_exp});
    end
    if (counting) begin
      check_val({tag, "_onebit"}, $countones(q ^ prev), 32'd1);
    end
  endtask

  initial begin
    seq_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    load_en = 1'b0;
    d       = '0;
    model_q = '0;

    // Reset and hold
    step("reset0", 1'b1, 1'b0, 4'h0);
    step("reset1", 1'b1, 1'b0, 4'h0);
    step("reset2", 1'b1, 1'b0, 4'h0);

    // Load then count
    step("idle_after_rst", 1'b0, 1'b0, 4'h0);
    check_val("first_count_const", {28'd0, q}, 32'h1);
    step("load_0011", 1'b0, 1'b1, 4'b0011);
    for (int i = 0; i < 4; i++) step("count_after_load", 1'b0, 1'b0, 4'h0);
    check_val("after_load_seq_end", {28'd0, q}, 32'b0101);

    // Full cycle and wrap
    step("reset_full", 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      step("full_cycle", 1'b0, 1'b0, 4'h0);
      check_val("full_cycle_tbl", {28'd0, q}, {28'd0, seq_tbl[(i + 1) % 16]});
    end

    // Priority: reset beats load
    step("prio_reset", 1'b1, 1'b1, 4'b1010);
    check_val("prio_reset_zero", {28'd0, q}, 32'h0);
    step("prio_load", 1'b0, 1'b1, 4'b1010);

    // Reset mid-operation
    step("load_1101", 1'b0, 1'b1, 4'b1101);
    step("mid_cnt0", 1'b0, 1'b0, 4'h0);
    step("mid_cnt1", 1'b0, 1'b0, 4'h0);
    check_val("mid_cnt_1110", {28'd0, q}, 32'b1110);
    step("mid_reset", 1'b1, 1'b0, 4'h5);
    step("mid_resume", 1'b0, 1'b0, 4'h0);

    // Load at wrap point, then multi-bit load
    step("load_1000", 1'b0, 1'b1, 4'b1000);
    step("wrap_from_load", 1'b0, 1'b0, 4'h0);
    step("load_0110", 1'b0, 1'b1, 4'b0110);

    // Load held several cycles, then resume
    for (int i = 0; i < 3; i++) step("load_hold", 1'b0, 1'b1, 4'b1011);
    step("resume_hold", 1'b0, 1'b0, 4'h0);

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      logic r;
      logic l;
      r = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 4) == 0);
      step("rand", r, l, 4'($urandom_range(0, 15)));
    end

    check_val("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
